// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin sync, clock deglitch, 11-bit frame FSM with
// per-bit timeout, and a show-ahead byte FIFO with sticky error flags.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          fclk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Two-flop synchronisers; reset high to match an idle bus.
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  logic          filt_q, filt_d;
  logic [FW-1:0] run_q, run_d;
  logic          strobe_q, strobe_d;

  always_comb begin
    filt_d   = filt_q;
    run_d    = '0;
    strobe_d = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (run_q == FILT_LAST) begin
        filt_d   = clk_s2_q;
        strobe_d = ~clk_s2_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      filt_q   <= 1'b1;
      run_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      run_q    <= run_d;
      strobe_q <= strobe_d;
    end
  end

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          pok_q, pok_d;
  logic [TW-1:0] to_q, to_d;
  logic          push, perr_ev, ferr_ev;

  // A strobe always wins over the timeout, so a late edge still counts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pok_d   = pok_q;
    to_d    = to_q;
    push    = 1'b0;
    perr_ev = 1'b0;
    ferr_ev = 1'b0;
    if (state_q == ST_IDLE || strobe_q) begin
      to_d = '0;
    end else if (to_q != TO_LAST) begin
      to_d = to_q + 1'b1;
    end
    if (strobe_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d[idx_q] = dat_s2_q;
          if (idx_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        ST_PARITY: begin
          pok_d   = ^{shift_q, dat_s2_q};
          state_d = ST_STOP;
        end
        default: begin
          push    = dat_s2_q & pok_q;
          perr_ev = ~pok_q;
          ferr_ev = ~dat_s2_q;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && to_q == TO_LAST) begin
      state_d = ST_IDLE;
      ferr_ev = 1'b1;
    end
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      pok_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      pok_q   <= pok_d;
      to_q    <= to_d;
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          pop, wr, ovf_ev, full_w;

  // When full, a simultaneous pop frees the slot the write lands in.
  assign full_w = (count_q == DEPTH_C);
  assign pop    = rd_en & (count_q != '0);
  assign wr     = push & (~full_w | pop);
  assign ovf_ev = push & full_w & ~pop;

  always_comb begin
    count_d = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      parity_err <= (parity_err & ~clr_err) | perr_ev;
      frame_err  <= (frame_err  & ~clr_err) | ferr_ev;
      overflow   <= (overflow   & ~clr_err) | ovf_ev;
    end
  end

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = full_w;
  assign rd_data = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It deglitches the PS/2 clock and recovers 11-bit frames (start, 8 data LSB-first, odd parity, stop). Good bytes go into a show-ahead FIFO read by the CPU bus through a synchronous pop strobe. It adds per-frame timeout recovery and sticky parity, framing and overflow error flags, so bursts of scancodes (E0/F0 prefixes) are not lost between CPU reads.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
FILTER_LEN, 8, consecutive equal fclk samples needed before the filtered PS/2 clock changes level; >= 1
TIMEOUT_CYCLES, 50000, fclk cycles allowed between successive falling edges inside a frame before abort

Ports:
fclk  input  1  system clock
rst  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
ps2_data  input  1  raw PS/2 data pin (asynchronous)
rd_en  input  1  pop strobe, fclk-synchronous, one entry per high cycle
clr_err  input  1  clears all sticky error flags
rd_data  output  8  FIFO head byte (show-ahead); 0 when empty
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH
parity_err  output  1  sticky: frame received with bad parity
frame_err  output  1  sticky: stop bit 0 or timeout abort
overflow  output  1  sticky: good byte dropped because FIFO full

Behaviour:
- Reset (async, rst=0): FSM IDLE, FIFO pointers 0, count=0, empty=1, full=0, rd_data=0, all error flags 0. Sync flops and filtered clock reset to 1 (idle bus). Filter and timeout counters reset to 0.
- Input conditioning: ps2_clk and ps2_data each pass through 2 flops. Filtered clock changes level only after FILTER_LEN consecutive synchronized samples differ from its current value; any matching sample restarts the run count.
- Strobe: one-cycle pulse on a filtered-clock 1->0 transition. Data is sampled from synchronized ps2_data in the strobe cycle. Pin edge to strobe latency = 2 + FILTER_LEN cycles.
- FSM (advances only on strobe, except timeout):
  IDLE: data=0 -> DATA, bit index 0. data=1 -> stay IDLE, no error.
  DATA: shift bit into position index, LSB first. After index 7 -> PARITY.
  PARITY: parity_ok = (XOR of 8 data bits XOR sampled bit) == 1. -> STOP.
  STOP: data=1 and parity_ok -> push byte. Parity bad -> set parity_err, no push. Data=0 -> set frame_err, no push. Both faults set both flags. -> IDLE.
- Timeout: counter clears on every strobe and while in IDLE. In any non-IDLE state, reaching TIMEOUT_CYCLES-1 without a strobe -> IDLE, set frame_err, discard the partial byte. An idle bus never times out.
- FIFO: the push is written on the STOP-strobe clock edge; rd_data, empty and count update on the next cycle. rd_en with empty=1 is ignored with no state change. A push with full=1 and no pop drops the byte and sets overflow. A push and pop in the same cycle both succeed, even when full or when count=1, and count is unchanged. Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH).
- Sticky flags: cleared by clr_err on the next edge. If an error event and clr_err occur in the same cycle, the flag ends set.
- A reset asserted mid-frame or with FIFO contents discards everything. After release, the receiver resynchronises at the next start bit.

Test Plan:
- Send frame 0x1C (parity bit 0, stop 1), FILTER_LEN=8 -> after stop strobe, empty 1->0, rd_data=0x1C, count=1. Pulse rd_en once -> empty=1, count=0, no error flags set.
- Send 0xE0,0xF0,0x5A back-to-back with no reads -> count=3. Three rd_en pulses return 0xE0, 0xF0, 0x5A in order.
- 0x5A sent with parity bit 0 -> parity_err=1, count unchanged. Pulse clr_err -> parity_err=0. Then 0x5A sent with correct parity 1 -> accepted.
- Send start plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES (use 200 in bench) -> frame_err=1, FSM IDLE. A following full 0x1C frame is received correctly.
- FIFO_DEPTH=4: send 5 frames 0x01..0x05 -> full=1, count=4, overflow=1, contents 0x01..0x04. Then push 0x06 while holding rd_en in the push cycle -> count stays 4, head becomes 0x02.
- Inject 3-cycle low glitches on ps2_clk (shorter than FILTER_LEN) during IDLE and mid-frame -> no strobes generated, the frame in progress completes correctly. Assert rst mid-frame -> all outputs return to reset values immediately.
